// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported unified memory between instruction fetch and data memory stages.
// Ports: clk, reset (sync, active-high);
//   fetch port  if_req/if_addr  -> if_rdata/if_ready;
//   data port   dm_req/dm_we/dm_addr/dm_wdata -> dm_rdata/dm_ready;
//   memory side mem_en/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready.
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin on collisions instead of fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic          r_own_dm, r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_if_rdata, r_dm_rdata;
  logic          w_req, w_pick_dm, w_grant;
  assign w_req   = if_req | dm_req;
  assign w_grant = (r_state == IDLE) && w_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_rr_dm set means data port is favoured on the next collision
  logic r_rr_dm;
  always_ff @(posedge clk) begin
    if (reset) r_rr_dm <= 1'b0;
    else if (w_grant) r_rr_dm <= !w_pick_dm;
  end
  assign w_pick_dm = dm_req && (!if_req || r_rr_dm);
`else
  assign w_pick_dm = dm_req;
`endif
  // DONE never evaluates requests, so a request held through the pulse cannot re-trigger
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (w_req ? BUSY : IDLE) :
             (r_state == BUSY) ? (mem_ready ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_own_dm   <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_own_dm <= w_pick_dm;
        r_we     <= w_pick_dm && dm_we;
        r_addr   <= w_pick_dm ? dm_addr : if_addr;
        r_wdata  <= w_pick_dm ? dm_wdata : '0;
      end
      if (r_state == BUSY && mem_ready) begin
        if (!r_own_dm) r_if_rdata <= mem_rdata;
        else if (!r_we) r_dm_rdata <= mem_rdata;
      end
    end
  end
  assign mem_en    = (r_state == BUSY);
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_ready  = (r_state == DONE) && !r_own_dm;
  assign dm_ready  = (r_state == DONE) && r_own_dm;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized bench for mem_arbiter against a transaction-level timeline model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_done = 0;

  function automatic void check(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endfunction

  // Model: one in-flight transaction stamped with the cycle its ready pulse is due.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_active = 0, m_own_dm = 0, m_we = 0, m_last_dm = 1, m_after_rst = 0;
  int          m_done = -1;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_dm_rd = '0;
  bit          e_en, e_ifr, e_dmr;

  // Called once at the start of every cycle, before the bench changes inputs,
  // so the input wires still hold what the DUT sampled at this edge.
  task automatic model_step();
    bit pick;
    cyc++;
    if (reset) begin
      m_active = 0; m_own_dm = 0; m_we = 0; m_addr = '0; m_wdata = '0;
      m_if_rd = '0; m_dm_rd = '0; m_last_dm = 1; m_done = -1; m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      if (m_active && m_done == cyc - 1) m_active = 0;
      else if (m_active && m_done < 0 && mem_ready) begin
        m_done = cyc;
        n_done++;
        if (!m_own_dm) m_if_rd = mem_rdata;
        else if (!m_we) m_dm_rd = mem_rdata;
      end else if (!m_active && (if_req || dm_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick = dm_req && (!if_req || !m_last_dm);
`else
        pick = dm_req;
`endif
        m_active = 1; m_own_dm = pick; m_done = -1; m_last_dm = pick;
        m_addr  = pick ? dm_addr : if_addr;
        m_we    = pick && dm_we;
        m_wdata = pick ? dm_wdata : '0;
      end
    end
    e_en  = m_active && m_done < 0;
    e_ifr = m_active && m_done == cyc && !m_own_dm;
    e_dmr = m_active && m_done == cyc && m_own_dm;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_en", mem_en, e_en);
      check("if_ready", if_ready, e_ifr);
      check("dm_ready", dm_ready, e_dmr);
      check("if_rdata", if_rdata, m_if_rd);
      check("dm_rdata", dm_rdata, m_dm_rd);
      if (e_en || m_after_rst) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_we", mem_we, e_en && m_we);
      end
      if ((e_en && m_we) || m_after_rst) check("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk_en = 1;
  endtask

  bit if_p, dm_p;

  initial begin
    tick();
    tick();
    reset = 0;
    // reset values
    tick();
    @(negedge clk);
    check("rst mem_en", mem_en, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst if_rdata", if_rdata, 0);
    // single fetch, address change after grant ignored
    tick();
    if_req = 1; if_addr = 32'h40;
    tick();
    if_addr = 32'h44; mem_ready = 1; mem_rdata = 32'h2008_0005;
    @(negedge clk);
    check("fetch mem_en c1", mem_en, 1);
    check("fetch mem_addr c1", mem_addr, 32'h40);
    tick();
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    check("fetch if_ready c2", if_ready, 1);
    check("fetch if_rdata c2", if_rdata, 32'h2008_0005);
    tick();
    @(negedge clk);
    check("fetch if_ready c3", if_ready, 0);
    check("fetch mem_en c3", mem_en, 0);
    // data write with three memory cycles
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      dm_addr = 32'h999; dm_wdata = '0; mem_ready = (i == 2); mem_rdata = 32'h1234_5678;
      @(negedge clk);
      check("wr mem_en", mem_en, 1);
      check("wr mem_we", mem_we, 1);
      check("wr mem_addr", mem_addr, 32'h100);
      check("wr mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    tick();
    mem_ready = 0; dm_req = 0; dm_we = 0;
    @(negedge clk);
    check("wr dm_ready", dm_ready, 1);
    check("wr dm_rdata kept", dm_rdata, 0);
    tick();
    @(negedge clk);
    check("wr dm_ready after", dm_ready, 0);
    // contention
    tick();
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_addr = 32'h200; dm_we = 0;
    mem_ready = 1; mem_rdata = 32'hA5A5_0001;
    tick();
    @(negedge clk);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("rr first addr", mem_addr, 32'h80);
    tick();
    if_addr = 32'h84; mem_rdata = 32'hA5A5_0002;
    @(negedge clk);
    check("rr if_ready", if_ready, 1);
    check("rr if_rdata", if_rdata, 32'hA5A5_0001);
    tick();
    tick();
    @(negedge clk);
    check("rr second addr", mem_addr, 32'h200);
    tick();
    dm_req = 0; mem_rdata = 32'hA5A5_0003;
    @(negedge clk);
    check("rr dm_ready", dm_ready, 1);
    check("rr dm_rdata", dm_rdata, 32'hA5A5_0002);
    tick();
    tick();
    @(negedge clk);
    check("rr third addr", mem_addr, 32'h84);
    tick();
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    check("rr if_ready 2", if_ready, 1);
    check("rr if_rdata 2", if_rdata, 32'hA5A5_0003);
`else
    check("prio first addr", mem_addr, 32'h200);
    tick();
    dm_req = 0; mem_rdata = 32'hA5A5_0002;
    @(negedge clk);
    check("prio dm_ready", dm_ready, 1);
    check("prio if_ready early", if_ready, 0);
    check("prio dm_rdata", dm_rdata, 32'hA5A5_0001);
    tick();
    tick();
    @(negedge clk);
    check("prio second addr", mem_addr, 32'h80);
    tick();
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    check("prio if_ready", if_ready, 1);
    check("prio if_rdata", if_rdata, 32'hA5A5_0002);
`endif
    // reset while busy
    tick();
    tick();
    if_req = 1; if_addr = 32'h300; mem_ready = 0;
    tick();
    reset = 1;
    @(negedge clk);
    check("rstb mem_en busy", mem_en, 1);
    tick();
    reset = 0; if_req = 0; mem_ready = 1;
    @(negedge clk);
    check("rstb mem_en", mem_en, 0);
    check("rstb if_ready", if_ready, 0);
    check("rstb if_rdata", if_rdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_ready = 0;
      @(negedge clk);
      check("rstb late ready", if_ready | dm_ready | mem_en, 0);
    end
    // randomized traffic
    if_p = 0; dm_p = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (e_ifr) if_p = $urandom_range(0, 1) == 1;
      else if (!if_p) if_p = $urandom_range(0, 3) == 0;
      if (e_dmr) dm_p = $urandom_range(0, 1) == 1;
      else if (!dm_p) dm_p = $urandom_range(0, 3) == 0;
      if_req = if_p; dm_req = dm_p;
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      dm_we = $urandom_range(0, 1) == 1;
    end
    tick();
    @(negedge clk);
    check("random activity", n_done > 100, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that lets the pipelined processor's instruction-fetch stage and data-memory stage share one single-ported unified memory. It accepts one request per port, grants one at a time, drives the memory handshake, and returns read data plus a one-cycle completion pulse. While its request is pending, each pipeline stage stalls on `!ready`.

## Interface
Parameters:
- `AW`, 32: address width in bits.
- `DW`, 32: data width in bits.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: instruction-fetch request; held high until `if_ready`.
- `if_addr` in AW: fetch address; sampled at grant.
- `if_rdata` out DW: fetched word; registered.
- `if_ready` out 1: one-cycle completion pulse for the fetch.
- `dm_req` in 1: data request; held high until `dm_ready`.
- `dm_we` in 1: 1 = write, 0 = read; sampled at grant.
- `dm_addr` in AW: data address; sampled at grant.
- `dm_wdata` in DW: write data; sampled at grant.
- `dm_rdata` out DW: load data; registered.
- `dm_ready` out 1: one-cycle completion pulse for the data access.
- `mem_en` out 1: memory access active; held until `mem_ready`.
- `mem_we` out 1: memory write strobe; valid while `mem_en`.
- `mem_addr` out AW: memory address; stable while `mem_en`.
- `mem_wdata` out DW: memory write data; stable while `mem_en`.
- `mem_rdata` in DW: memory read data; valid in the cycle `mem_ready` is high.
- `mem_ready` in 1: memory completion; ignored unless state is BUSY.

## Operation
- FSM states:
  - IDLE -> BUSY on any request.
  - BUSY -> DONE on `mem_ready`.
  - DONE -> IDLE unconditionally.
- IDLE: evaluate `if_req` and `dm_req`.
  - On a grant, latch the winner's addr/we/wdata into internal registers, record the owner (IF or DM), and enter BUSY.
  - No request: stay in IDLE.
- Default priority: DM wins when both requests are high. The MEM stage is the older instruction, so it always makes progress.
- IF grant: `mem_we` is forced to 0.
- BUSY:
  - `mem_en`=1. `mem_we`, `mem_addr` and `mem_wdata` come from the latched registers. Requester input changes are ignored.
  - On `mem_ready`, capture `mem_rdata` into the owner's rdata register and enter DONE. For a DM write, `dm_rdata` is left unchanged.
- DONE:
  - The owner's ready=1 for exactly this cycle.
  - `mem_en`=0.
  - Requests are not evaluated, so a req still high in this cycle cannot re-trigger.
  - Next state is IDLE.
- The rdata registers hold their value until the next completion for that port.
- At most one access is outstanding. The non-granted port simply waits; its `req` stays high.

## Timing
- Reset, checked on the cycle after the `reset` edge:
  - State = IDLE.
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `if_ready`=0, `dm_ready`=0.
  - `if_rdata`=0, `dm_rdata`=0.
  - Round-robin pointer = IF-next (see Configuration).
- Reset mid-access: the access is abandoned, `mem_en` falls at the reset edge, and no ready pulse is issued.
- `mem_*` outputs are driven from registers or state only; there is no combinational path from `mem_ready` to `mem_en`.
- Latency, counted from the cycle a request is first seen in IDLE (cycle 0):
  - `mem_en` rises in cycle 1.
  - If `mem_ready` arrives in cycle N (N≥1), ready pulses in cycle N+1.
  - The arbiter is back in IDLE in cycle N+2.
- Minimum occupancy: 3 cycles per access, with `mem_ready` in the first `mem_en` cycle.
- Both requests arrive in cycle 0: the second granted request sees `mem_en` no earlier than the cycle after the first one's DONE.
- `mem_ready` asserted outside BUSY has no effect.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - When both requests are high in IDLE, grant the port not granted most recently.
  - A 1-bit pointer updates on every grant.
  - The reset pointer favours IF.
- Not defined: fixed DM-over-IF priority, and there is no pointer register.
- Single-request behaviour is identical in both builds.

## Test plan
- Single fetch: `if_req`=1, `if_addr`=0x40, `mem_ready` in the 1st `mem_en` cycle with `mem_rdata`=0x2008_0005 -> `mem_en` in cycle 1, `if_ready` pulse in cycle 2 with `if_rdata`=0x2008_0005, IDLE in cycle 3.
- DM write with wait states: `dm_we`=1, `dm_addr`=0x100, `dm_wdata`=0xDEADBEEF, `mem_ready` after 3 `mem_en` cycles:
  - `mem_we`/`mem_addr`/`mem_wdata` stay stable for all 3 cycles.
  - One `dm_ready` pulse.
  - `dm_rdata` unchanged.
- Contention: both requests high in cycle 0.
  - Default build: DM is served first, then IF; `if_ready` arrives after `dm_ready`.
  - With the macro: IF first, and on the next collision DM first.
- Input change after grant: change `if_addr` 0x40 -> 0x44 in cycle 1 -> `mem_addr` stays 0x40.
- Held request: `req` held high through the DONE cycle -> no duplicate access; the next access starts only on an IDLE-evaluated request.
- Reset during BUSY: `reset`=1 for one cycle -> `mem_en`=0 at the next edge, no ready pulse, and a later `mem_ready` is ignored.
